periph_port_arbiter: RTL and testbench
======================================

Name: periph_port_arbiter

Overview:
Round-robin arbiter that shares one core-side peripheral demux port among NUM_REQ requesters (e.g. core data port, debug module, HWPE control).
Sits between the requesters and the periph demux core-side port.
Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued the request.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
MAX_OUTSTANDING, 2, ID FIFO depth (1..8); maximum number of granted requests without a response

Ports:
clk  in  1  clock
rst_i  in  1  synchronous active-high reset
data_req_i  in  NUM_REQ  per-requester request
data_add_i  in  NUM_REQ x ADDR_WIDTH  per-requester address
data_wen_i  in  NUM_REQ  per-requester write-enable, 1 = read
data_wdata_i  in  NUM_REQ x DATA_WIDTH  per-requester write data
data_be_i  in  NUM_REQ x BE_WIDTH  per-requester byte enables
data_gnt_o  out  NUM_REQ  per-requester grant
data_r_valid_o  out  NUM_REQ  per-requester response valid
data_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
data_r_opc_o  out  1  response error, broadcast to all requesters
data_req_o  out  1  request to demux
data_add_o  out  ADDR_WIDTH  address to demux
data_wen_o  out  1  write-enable to demux
data_wdata_o  out  DATA_WIDTH  write data to demux
data_be_o  out  BE_WIDTH  byte enables to demux
data_gnt_i  in  1  grant from demux
data_r_valid_i  in  1  response valid from demux
data_r_rdata_i  in  DATA_WIDTH  response data from demux
data_r_opc_i  in  1  response error from demux

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_i is synchronous, active-high. Sampled at posedge clk, it clears the RR pointer to 0, the FIFO pointers and the FIFO count.
- Request path (combinational):
  - Winner = first asserted data_req_i[k] searching upward from rr_ptr, wrapping at NUM_REQ.
  - data_req_o = any request AND NOT full.
  - Address, wen, wdata and be are muxed from the winner. When there is no winner, these outputs are 0.
  - data_gnt_o[winner] = data_gnt_i AND NOT full. All other grants are 0.
- Handshake:
  - A handshake occurs when data_req_o AND data_gnt_i are both high.
  - On a handshake: push winner index into the ID FIFO, and set rr_ptr = (winner+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no handshake, so a stalled winner keeps priority.
- Full condition:
  - full = (count == MAX_OUTSTANDING).
  - full is evaluated on registered count only. A same-cycle pop does not unblock the grant (no comb path r_valid -> gnt).
- Response path:
  - On data_r_valid_i, pop the FIFO head h.
  - data_r_valid_o[h] = 1; all other bits are 0.
  - data_r_rdata_o and data_r_opc_o pass through combinationally, zero-latency.
- FIFO count update:
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - data_r_valid_i with an empty FIFO: ignored, no output valid, count stays 0. Flagged by a simulation assertion.
- Latency: the arbiter adds 0 cycles to both the request path and the response path.
- Reset values:
  - All outputs are 0 while rst_i is asserted and in the first cycle after it with no requests.
  - Reset mid-transaction drops all outstanding IDs. Late responses arriving after reset are treated as spurious and ignored.
- Requester protocol: a requester must hold data_req_i and its payload stable until granted. Violation is checked by a bench assertion only.

Optional Feature:
PERIPH_ARB_PRIO0_EN
- Defined: requester 0 has fixed highest priority. If data_req_i[0] is high it wins regardless of rr_ptr, and rr_ptr is not updated on its handshake. Requesters 1..NUM_REQ-1 round-robin among themselves.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

Decomposition:
- Package periph_arb_pkg: parameterised function for ID width (clog2 of NUM_REQ, minimum 1) and for count width (clog2 of MAX_OUTSTANDING+1).
- Sub-module periph_arb_id_fifo: synchronous FIFO of requester IDs.
  - Signals: push, pop, data in, head out, count, full, empty.
  - Same reset as the arbiter (rst_i).

Test Plan:
1. NUM_REQ=4, all requesters requesting continuously, data_gnt_i=1, 1-cycle responses -> grants in order 0,1,2,3,0,...; each response returns to the matching requester with its rdata, e.g. 0xA5A5_0000+k.
2. MAX_OUTSTANDING=2, data_r_valid_i held 0 -> exactly 2 grants, then data_gnt_o=0 and data_req_o=0; one response -> next grant the following cycle, not the same cycle.
3. data_gnt_i=0 for 3 cycles while req 2 is the winner and req 3 is also requesting -> req 2 stays the winner; after data_gnt_i=1, req 2 is granted, then req 3.
4. Push and pop in the same cycle with count=1 -> count stays 1; the next response routes to the newly pushed ID.
5. Assert rst_i with 2 outstanding; then data_r_valid_i=1 -> all data_r_valid_o=0, count=0, rr_ptr=0; first grant after reset goes to the lowest requesting index.
6. PERIPH_ARB_PRIO0_EN defined, requesters 0 and 2 requesting continuously -> requester 0 granted every cycle; after req 0 drops, req 2 is granted and round-robin resumes among 1..3.

Source files
------------

// File: rtl/periph_arb_pkg.sv
// Shared sizing helpers for the peripheral port arbiter.
// Optional build macro used by the arbiter: PERIPH_ARB_PRIO0_EN.
package periph_arb_pkg;

  // Requester ID width: clog2(num_req), at least 1 bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // FIFO pointer width: clog2(depth), at least 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/periph_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding transactions.
// Push is ignored when full, pop is ignored when empty.
module periph_arb_id_fifo
  import periph_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ID_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        push,
  input  logic                        pop,
  input  logic [ID_W-1:0]             din,
  output logic [ID_W-1:0]             head,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // ID storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/periph_port_arbiter.sv
// Round-robin arbiter sharing one periph demux core-side port among NUM_REQ
// requesters; responses are routed back in order via an ID FIFO.
// Build macro PERIPH_ARB_PRIO0_EN: requester 0 gets fixed top priority and the
// remaining requesters round-robin among themselves.
module periph_port_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_i,
  input  logic [NUM_REQ-1:0]                   data_req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   data_add_i,
  input  logic [NUM_REQ-1:0]                   data_wen_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [NUM_REQ-1:0][BE_WIDTH-1:0]     data_be_i,
  output logic [NUM_REQ-1:0]                   data_gnt_o,
  output logic [NUM_REQ-1:0]                   data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  input  logic                                 data_gnt_i,
  input  logic                                 data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                data_r_rdata_i,
  input  logic                                 data_r_opc_i
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             handshake;
  logic             rr_upd;
  logic [ID_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // Winner search: first active request at or above rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
`ifdef PERIPH_ARB_PRIO0_EN
    if (data_req_i[0]) found = 1'b1;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && data_req_i[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  // Full is taken from the registered count only, so a pop never frees a slot same-cycle.
  assign data_req_o = found & ~fifo_full & ~rst_i;
  assign handshake  = data_req_o & data_gnt_i;
  assign rr_next    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
`ifdef PERIPH_ARB_PRIO0_EN
  assign rr_upd     = handshake & (winner != '0);
`else
  assign rr_upd     = handshake;
`endif

  // Request payload mux and one-hot grant towards the winner.
  always_comb begin
    data_gnt_o   = '0;
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    if (found && !rst_i) begin
      data_add_o   = data_add_i[winner];
      data_wen_o   = data_wen_i[winner];
      data_wdata_o = data_wdata_i[winner];
      data_be_o    = data_be_i[winner];
    end
    if (handshake) data_gnt_o[winner] = 1'b1;
  end

  // Response routing to the oldest outstanding requester; data passes straight through.
  always_comb begin
    data_r_valid_o = '0;
    data_r_rdata_o = rst_i ? '0 : data_r_rdata_i;
    data_r_opc_o   = data_r_opc_i & ~rst_i;
    if (data_r_valid_i && !fifo_empty && !rst_i) data_r_valid_o[fifo_head] = 1'b1;
  end

  // Round-robin pointer; held while the winner is stalled so it keeps priority.
  always_ff @(posedge clk) begin
    if (rst_i)       rr_ptr <= '0;
    else if (rr_upd) rr_ptr <= rr_next;
  end

  periph_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (handshake),
    .pop   (data_r_valid_i & ~rst_i),
    .din   (winner),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sanity checks: occupancy bound, and responses with nothing outstanding are dropped.
  always_ff @(posedge clk) begin
    if (!rst_i) begin
      assert (fifo_count <= CNT_W'(MAX_OUTSTANDING))
        else $error("periph_port_arbiter: ID FIFO occupancy above limit");
      assert (!(data_r_valid_i && fifo_empty))
        else $warning("periph_port_arbiter: response with no outstanding request dropped");
    end
  end

endmodule

// File: tb/tb_periph_port_arbiter.sv
// Bench for periph_port_arbiter: directed vector table, reset corner case,
// then random traffic checked against a queue-based reference model.
module tb_periph_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned MO = 2;
`ifdef PERIPH_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                     clk;
  logic                     rst_i;
  logic [NR-1:0]            data_req_i;
  logic [NR-1:0][AW-1:0]    data_add_i;
  logic [NR-1:0]            data_wen_i;
  logic [NR-1:0][DW-1:0]    data_wdata_i;
  logic [NR-1:0][BW-1:0]    data_be_i;
  logic [NR-1:0]            data_gnt_o;
  logic [NR-1:0]            data_r_valid_o;
  logic [DW-1:0]            data_r_rdata_o;
  logic                     data_r_opc_o;
  logic                     data_req_o;
  logic [AW-1:0]            data_add_o;
  logic                     data_wen_o;
  logic [DW-1:0]            data_wdata_o;
  logic [BW-1:0]            data_be_o;
  logic                     data_gnt_i;
  logic                     data_r_valid_i;
  logic [DW-1:0]            data_r_rdata_i;
  logic                     data_r_opc_i;

  periph_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
    .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
    .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
    .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i), .data_r_opc_i(data_r_opc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-requester payload, driven onto the packed input arrays.
  logic [AW-1:0] pay_add   [NR];
  logic          pay_wen   [NR];
  logic [DW-1:0] pay_wdata [NR];
  logic [BW-1:0] pay_be    [NR];

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      data_add_i[k]   = pay_add[k];
      data_wen_i[k]   = pay_wen[k];
      data_wdata_i[k] = pay_wdata[k];
      data_be_i[k]    = pay_be[k];
    end
  end

  // Reference model state: RR pointer and queue of outstanding requester IDs.
  int rr;
  int q[$];
  int n_chk;
  int n_err;

  // Protocol tracking: requests still waiting for a grant and their payload.
  bit            pend   [NR];
  logic [AW-1:0] pend_add [NR];
  logic [DW-1:0] pend_wd  [NR];

  logic [NR-1:0] e_gnt;
  logic [NR-1:0] e_rv;
  logic          e_req;

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic          gnt;
    logic          rv;
    logic [NR-1:0] egnt;
    logic          ereq;
    logic [NR-1:0] erv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock cycle: compare DUT outputs with the model, then advance the model.
  task automatic step();
    int  win;
    bit  full;
    logic [AW-1:0] e_add;
    logic          e_wen;
    logic [DW-1:0] e_wd;
    logic [BW-1:0] e_be;
    #1;
    for (int k = 0; k < NR; k++) begin
      if (!rst_i && pend[k])
        assert (data_req_i[k] && data_add_i[k] == pend_add[k] && data_wdata_i[k] == pend_wd[k])
          else $error("requester %0d dropped or changed its request before grant", k);
    end
    full = (q.size() == MO);
    win  = -1;
    if (!rst_i) begin
      if (PRIO && data_req_i[0]) win = 0;
      for (int i = 0; i < NR && win < 0; i++) begin
        if (data_req_i[(rr + i) % NR]) win = (rr + i) % NR;
      end
    end
    e_req = (win >= 0) && !full;
    e_gnt = '0;
    if (e_req && data_gnt_i) e_gnt[win] = 1'b1;
    e_add = (win >= 0) ? pay_add[win]   : '0;
    e_wen = (win >= 0) ? pay_wen[win]   : 1'b0;
    e_wd  = (win >= 0) ? pay_wdata[win] : '0;
    e_be  = (win >= 0) ? pay_be[win]    : '0;
    e_rv  = '0;
    if (!rst_i && data_r_valid_i && q.size() > 0) e_rv[q[0]] = 1'b1;

    chk("gnt",    32'(data_gnt_o),     32'(e_gnt));
    chk("req",    32'(data_req_o),     32'(e_req));
    chk("add",    32'(data_add_o),     32'(e_add));
    chk("wen",    32'(data_wen_o),     32'(e_wen));
    chk("wdata",  32'(data_wdata_o),   32'(e_wd));
    chk("be",     32'(data_be_o),      32'(e_be));
    chk("rvalid", 32'(data_r_valid_o), 32'(e_rv));
    chk("rdata",  32'(data_r_rdata_o), rst_i ? 32'd0 : 32'(data_r_rdata_i));
    chk("opc",    32'(data_r_opc_o),   32'(data_r_opc_i & ~rst_i));

    if (rst_i) begin
      q.delete();
      rr = 0;
    end else begin
      if (data_r_valid_i && q.size() > 0) void'(q.pop_front());
      if (e_req && data_gnt_i) begin
        q.push_back(win);
        if (!(PRIO && win == 0)) rr = (win + 1) % NR;
      end
    end
    for (int k = 0; k < NR; k++) begin
      pend[k]     = !rst_i && data_req_i[k] && !e_gnt[k];
      pend_add[k] = data_add_i[k];
      pend_wd[k]  = data_wdata_i[k];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rr    = 0;
    for (int k = 0; k < NR; k++) begin
      pay_add[k]   = 32'h1000_0000 + 32'(k) * 32'h100;
      pay_wen[k]   = k[0];
      pay_wdata[k] = 32'hD00D_0000 + 32'(k);
      pay_be[k]    = BW'(k + 1);
      pend[k]      = 1'b0;
    end
    rst_i = 1'b1; data_req_i = '0; data_gnt_i = 1'b0;
    data_r_valid_i = 1'b0; data_r_rdata_i = 32'hDEAD_BEEF; data_r_opc_i = 1'b1;

    // Reset: all outputs zero while rst_i is high.
    @(negedge clk);
    step();
    step();
    rst_i = 1'b0; data_r_rdata_i = '0; data_r_opc_i = 1'b0;
    step();
    chk("post_reset_gnt", 32'(data_gnt_o), 32'd0);

`ifdef PERIPH_ARB_PRIO0_EN
    // Requester 0 always wins, then 1..3 round-robin.
    tbl.push_back('{1'b0, 4'h5, 1'b1, 1'b0, 4'h1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h5, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h5, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h5, 1'b1, 1'b1, 4'h1, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'hA, 1'b1, 1'b1, 4'h8, 1'b1, 4'h4});
    tbl.push_back('{1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 4'h8});
    tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h2});
`else
    // Round-robin with 1-cycle responses.
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 4'h1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 4'h2});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 4'h4});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 4'h8});
    tbl.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0});
    // Full at MAX_OUTSTANDING; a pop unblocks the grant only on the next cycle.
    tbl.push_back('{1'b0, 4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h3, 1'b1, 1'b0, 4'h2, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0});
    tbl.push_back('{1'b0, 4'h3, 1'b1, 1'b1, 4'h0, 1'b0, 4'h1});
    tbl.push_back('{1'b0, 4'h3, 1'b1, 1'b0, 4'h1, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h2, 1'b1, 1'b1, 4'h0, 1'b0, 4'h2});
    // Push and pop together at count 1; next response goes to the new ID.
    tbl.push_back('{1'b0, 4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 4'h1});
    tbl.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h2});
    // Stalled winner 2 keeps priority over 3.
    tbl.push_back('{1'b0, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'hC, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'hC, 1'b1, 1'b0, 4'h4, 1'b1, 4'h0});
    tbl.push_back('{1'b0, 4'h8, 1'b1, 1'b1, 4'h8, 1'b1, 4'h4});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h8});
`endif

    foreach (tbl[r]) begin
      rst_i          = tbl[r].rst;
      data_req_i     = tbl[r].req;
      data_gnt_i     = tbl[r].gnt;
      data_r_valid_i = tbl[r].rv;
      data_r_rdata_i = 32'hA5A5_0000 + 32'(r);
      #1;
      chk($sformatf("tbl%0d_gnt", r),    32'(data_gnt_o),     32'(tbl[r].egnt));
      chk($sformatf("tbl%0d_req", r),    32'(data_req_o),     32'(tbl[r].ereq));
      chk($sformatf("tbl%0d_rvalid", r), 32'(data_r_valid_o), 32'(tbl[r].erv));
      step();
    end

    // Reset with two outstanding: the late response is dropped, RR restarts at 0.
    rst_i = 1'b0; data_gnt_i = 1'b1; data_r_valid_i = 1'b0;
    data_req_i = 4'b0011;
    step();
    data_req_i = 4'b0010;
    step();
    rst_i = 1'b1; data_req_i = '0; data_r_valid_i = 1'b1;
    step();
    rst_i = 1'b0; data_req_i = 4'b1010; data_r_valid_i = 1'b1;
    #1;
    chk("rst_late_rvalid", 32'(data_r_valid_o), 32'd0);
    chk("rst_first_gnt",   32'(data_gnt_o),     32'h2);
    step();

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < NR; k++) begin
        if (!pend[k]) begin
          data_req_i[k] = ($urandom_range(0, 2) != 0);
          pay_add[k]    = $urandom;
          pay_wen[k]    = 1'($urandom_range(0, 1));
          pay_wdata[k]  = $urandom;
          pay_be[k]     = BW'($urandom);
        end
      end
      data_gnt_i     = ($urandom_range(0, 3) != 0);
      data_r_valid_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      data_r_rdata_i = $urandom;
      data_r_opc_i   = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
